redmule_tile_tcdm_arbiter: RTL and testbench

//  Two-requester arbiter sharing one TCDM (HCI) port between the core data path (narrow) and RedMulE (HWPE) inside the tile.

---
 rtl/redmule_tile_tcdm_arbiter_pkg.sv | 14 +
 rtl/redmule_tile_tcdm_arbiter_owner_fifo.sv | 48 ++++
 rtl/redmule_tile_tcdm_arbiter.sv | 140 ++++++++++++++
 tb/tb_redmule_tile_tcdm_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/redmule_tile_tcdm_arbiter_pkg.sv
// Shared definitions for the tile TCDM arbiter: requester index and default sizing.
package redmule_tile_tcdm_arbiter_pkg;

  typedef enum logic {
    ARB_CORE = 1'b0,
    ARB_HWPE = 1'b1
  } arb_req_e;

  localparam int unsigned DEF_AW        = 32;
  localparam int unsigned DEF_DW        = 32;
  localparam int unsigned DEF_MAX_STALL = 7;
  localparam int unsigned DEF_N_OUTSTD  = 4;

endpackage

// File: rtl/redmule_tile_tcdm_arbiter_owner_fifo.sv
// 1-bit-wide synchronous FIFO recording the owner (1=core) of each in-flight TCDM request.
module redmule_tile_owner_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic [DEPTH-1:0] r_mem;
  logic             w_push;
  logic             w_pop;

  // Extra wrap bit distinguishes full from empty when the indices coincide.
  assign full_o  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign empty_o = (r_wptr == r_rptr);
  assign data_o  = r_mem[r_rptr[PW-1:0]];

  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_mem  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[PW-1:0]] <= data_i;
        r_wptr                <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/redmule_tile_tcdm_arbiter.sv
// Shares one TCDM port between the core data path and RedMulE: combinational grant,
// in-order response routing via an owner FIFO, and a starvation bound on the non-default side.
module redmule_tile_tcdm_arbiter
  import redmule_tile_tcdm_arbiter_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned MAX_STALL = DEF_MAX_STALL,
  parameter int unsigned N_OUTSTD  = DEF_N_OUTSTD
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            core_prio_i,

  input  logic            core_req_i,
  output logic            core_gnt_o,
  input  logic [AW-1:0]   core_add_i,
  input  logic            core_wen_i,
  input  logic [DW/8-1:0] core_be_i,
  input  logic [DW-1:0]   core_data_i,
  output logic            core_r_valid_o,
  output logic [DW-1:0]   core_r_data_o,

  input  logic            hwpe_req_i,
  output logic            hwpe_gnt_o,
  input  logic [AW-1:0]   hwpe_add_i,
  input  logic            hwpe_wen_i,
  input  logic [DW/8-1:0] hwpe_be_i,
  input  logic [DW-1:0]   hwpe_data_i,
  output logic            hwpe_r_valid_o,
  output logic [DW-1:0]   hwpe_r_data_o,

  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic [AW-1:0]   mem_add_o,
  output logic            mem_wen_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [DW-1:0]   mem_data_o,
  input  logic            mem_r_valid_i,
  input  logic [DW-1:0]   mem_r_data_i,

  output logic            stall_core_o,
  output logic            err_o
);

  localparam int unsigned CW = $clog2(MAX_STALL + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STALL);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] r_cnt;
  logic          r_prio;
  logic          r_err;

  arb_req_e w_win;
  arb_req_e w_def;
  arb_req_e w_nodef;
  logic     w_run;
  logic     w_both;
  logic     w_ovr;
  logic     w_hs;
  logic     w_full;
  logic     w_empty;
  logic     w_head;
  logic     w_pop;
  logic     w_nd_req;
  logic     w_nd_gnt;
  logic     w_d_gnt;

  assign w_run   = ~rst_i;
  assign w_def   = core_prio_i ? ARB_CORE : ARB_HWPE;
  assign w_nodef = core_prio_i ? ARB_HWPE : ARB_CORE;
  assign w_both  = core_req_i & hwpe_req_i;
  assign w_ovr   = w_both & (r_cnt == CNT_MAX);

  always_comb begin
    w_win = ARB_CORE;
    if (hwpe_req_i && !core_req_i) begin
      w_win = ARB_HWPE;
    end else if (w_both) begin
      w_win = w_ovr ? w_nodef : w_def;
    end
  end

  // Registered full only: a same-cycle pop does not free a slot for a new request.
  assign mem_req_o  = w_run & (core_req_i | hwpe_req_i) & ~w_full;
  assign w_hs       = mem_req_o & mem_gnt_i;
  assign core_gnt_o = w_hs & (w_win == ARB_CORE);
  assign hwpe_gnt_o = w_hs & (w_win == ARB_HWPE);

  assign mem_add_o  = (w_win == ARB_CORE) ? core_add_i  : hwpe_add_i;
  assign mem_wen_o  = (w_win == ARB_CORE) ? core_wen_i  : hwpe_wen_i;
  assign mem_be_o   = (w_win == ARB_CORE) ? core_be_i   : hwpe_be_i;
  assign mem_data_o = (w_win == ARB_CORE) ? core_data_i : hwpe_data_i;

  assign w_pop          = w_run & mem_r_valid_i & ~w_empty;
  assign core_r_valid_o = w_pop & w_head;
  assign hwpe_r_valid_o = w_pop & ~w_head;
  assign core_r_data_o  = w_run ? mem_r_data_i : '0;
  assign hwpe_r_data_o  = w_run ? mem_r_data_i : '0;

  assign stall_core_o = w_run & w_ovr & (w_nodef == ARB_CORE);
  assign err_o        = w_run & r_err;

  redmule_tile_owner_fifo #(
    .DEPTH (N_OUTSTD)
  ) i_owner_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_hs),
    .data_i  (w_win == ARB_CORE),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign w_nd_req = core_prio_i ? hwpe_req_i : core_req_i;
  assign w_nd_gnt = core_prio_i ? hwpe_gnt_o : core_gnt_o;
  assign w_d_gnt  = core_prio_i ? core_gnt_o : hwpe_gnt_o;

  always_ff @(posedge clk_i) begin
    r_prio <= core_prio_i;
    if (rst_i) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (core_prio_i != r_prio) begin
        r_cnt <= '0;
      end else if (!w_nd_req || w_nd_gnt) begin
        r_cnt <= '0;
      end else if (w_d_gnt && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (mem_r_valid_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_redmule_tile_tcdm_arbiter.sv
// Directed self-checking bench for the tile TCDM arbiter.
module tb_redmule_tile_tcdm_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_prio_i;
  logic        core_req_i, core_gnt_o, core_wen_i, core_r_valid_o;
  logic [31:0] core_add_i, core_data_i, core_r_data_o;
  logic [3:0]  core_be_i;
  logic        hwpe_req_i, hwpe_gnt_o, hwpe_wen_i, hwpe_r_valid_o;
  logic [31:0] hwpe_add_i, hwpe_data_i, hwpe_r_data_o;
  logic [3:0]  hwpe_be_i;
  logic        mem_req_o, mem_gnt_i, mem_wen_o, mem_r_valid_i;
  logic [31:0] mem_add_o, mem_data_o, mem_r_data_i;
  logic [3:0]  mem_be_o;
  logic        stall_core_o, err_o;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk_i = ~clk_i;

  redmule_tile_tcdm_arbiter #(
    .AW        (32),
    .DW        (32),
    .MAX_STALL (7),
    .N_OUTSTD  (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .core_prio_i    (core_prio_i),
    .core_req_i     (core_req_i),
    .core_gnt_o     (core_gnt_o),
    .core_add_i     (core_add_i),
    .core_wen_i     (core_wen_i),
    .core_be_i      (core_be_i),
    .core_data_i    (core_data_i),
    .core_r_valid_o (core_r_valid_o),
    .core_r_data_o  (core_r_data_o),
    .hwpe_req_i     (hwpe_req_i),
    .hwpe_gnt_o     (hwpe_gnt_o),
    .hwpe_add_i     (hwpe_add_i),
    .hwpe_wen_i     (hwpe_wen_i),
    .hwpe_be_i      (hwpe_be_i),
    .hwpe_data_i    (hwpe_data_i),
    .hwpe_r_valid_o (hwpe_r_valid_o),
    .hwpe_r_data_o  (hwpe_r_data_o),
    .mem_req_o      (mem_req_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_add_o      (mem_add_o),
    .mem_wen_o      (mem_wen_o),
    .mem_be_o       (mem_be_o),
    .mem_data_o     (mem_data_o),
    .mem_r_valid_i  (mem_r_valid_i),
    .mem_r_data_i   (mem_r_data_i),
    .stall_core_o   (stall_core_o),
    .err_o          (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_i = 1'b1; core_prio_i = 1'b0;
    core_req_i = 0; core_add_i = '0; core_wen_i = 1; core_be_i = 4'hF; core_data_i = '0;
    hwpe_req_i = 0; hwpe_add_i = 32'h200; hwpe_wen_i = 1; hwpe_be_i = 4'hF; hwpe_data_i = 32'h55;
    mem_gnt_i = 0; mem_r_valid_i = 0; mem_r_data_i = '0;

    // Reset state: outputs forced low even with a pending request
    step(); step();
    core_req_i = 1; settle();
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_core_gnt", core_gnt_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_stall", stall_core_o, 0);

    // Test 1: core only, three reads, latency 1
    step(); rst_i = 0; core_req_i = 1; core_add_i = 32'h100; mem_gnt_i = 1; settle();
    chk("t1_gnt0", core_gnt_o, 1);
    chk("t1_add0", mem_add_o, 32'h100);
    chk("t1_hgnt0", hwpe_gnt_o, 0);
    step(); core_add_i = 32'h104; mem_r_valid_i = 1; mem_r_data_i = 32'hD0; settle();
    chk("t1_gnt1", core_gnt_o, 1);
    chk("t1_rv0", core_r_valid_o, 1);
    chk("t1_rd0", core_r_data_o, 32'hD0);
    chk("t1_hrv0", hwpe_r_valid_o, 0);
    step(); core_add_i = 32'h108; mem_r_data_i = 32'hD1; settle();
    chk("t1_gnt2", core_gnt_o, 1);
    chk("t1_rv1", core_r_valid_o, 1);
    chk("t1_rd1", core_r_data_o, 32'hD1);
    step(); core_req_i = 0; mem_r_data_i = 32'hD2; settle();
    chk("t1_rv2", core_r_valid_o, 1);
    chk("t1_rd2", core_r_data_o, 32'hD2);
    chk("t1_req_idle", mem_req_o, 0);
    chk("t1_hrv2", hwpe_r_valid_o, 0);
    step(); mem_r_valid_i = 0; settle();
    chk("t1_rv_end", core_r_valid_o, 0);
    chk("t1_err", err_o, 0);

    // Test 2: both requesting, HWPE default: 7 HWPE wins then one forced core win
    core_add_i = 32'h300;
    for (int i = 0; i < 16; i++) begin
      step(); core_req_i = 1; hwpe_req_i = 1; mem_gnt_i = 1;
      mem_r_valid_i = (i >= 1); mem_r_data_i = 32'h1000 + i; settle();
      chk($sformatf("t2_cgnt%0d", i), core_gnt_o, (i % 8 == 7));
      chk($sformatf("t2_hgnt%0d", i), hwpe_gnt_o, (i % 8 != 7));
      chk($sformatf("t2_stall%0d", i), stall_core_o, (i % 8 == 7));
      if (i >= 1) chk($sformatf("t2_crv%0d", i), core_r_valid_o, ((i - 1) % 8 == 7));
    end
    chk("t2_add_core", mem_add_o, 32'h300);
    step(); core_req_i = 0; hwpe_req_i = 0; mem_r_valid_i = 1; mem_r_data_i = 32'hC0; settle();
    chk("t2_last_crv", core_r_valid_o, 1);
    chk("t2_last_hrv", hwpe_r_valid_o, 0);

    // Test 3: grants C,H,H,C with latency 3
    step(); core_prio_i = 1; mem_r_valid_i = 0; core_req_i = 1; core_add_i = 32'h10; settle();
    chk("t3_g0c", core_gnt_o, 1);
    step(); core_req_i = 0; hwpe_req_i = 1; hwpe_add_i = 32'h20; settle();
    chk("t3_g1h", hwpe_gnt_o, 1);
    chk("t3_a1", mem_add_o, 32'h20);
    step(); hwpe_add_i = 32'h24; settle();
    chk("t3_g2h", hwpe_gnt_o, 1);
    step(); hwpe_req_i = 0; core_req_i = 1; core_add_i = 32'h14;
    mem_r_valid_i = 1; mem_r_data_i = 32'hA0; settle();
    chk("t3_g3c", core_gnt_o, 1);
    chk("t3_r0c", core_r_valid_o, 1);
    chk("t3_r0h", hwpe_r_valid_o, 0);
    chk("t3_d0", core_r_data_o, 32'hA0);
    step(); core_req_i = 0; mem_r_data_i = 32'hA1; settle();
    chk("t3_r1h", hwpe_r_valid_o, 1);
    chk("t3_r1c", core_r_valid_o, 0);
    chk("t3_d1", hwpe_r_data_o, 32'hA1);
    step(); mem_r_data_i = 32'hA2; settle();
    chk("t3_r2h", hwpe_r_valid_o, 1);
    chk("t3_d2", hwpe_r_data_o, 32'hA2);
    step(); mem_r_data_i = 32'hA3; settle();
    chk("t3_r3c", core_r_valid_o, 1);
    chk("t3_r3h", hwpe_r_valid_o, 0);
    chk("t3_d3", core_r_data_o, 32'hA3);

    // Test 4: no responses -> four handshakes then blocked; registered full
    step(); mem_r_valid_i = 0; core_req_i = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      settle();
      chk($sformatf("t4_gnt%0d", i), core_gnt_o, 1);
    end
    step(); settle();
    chk("t4_full_req", mem_req_o, 0);
    chk("t4_full_gnt", core_gnt_o, 0);
    step(); mem_r_valid_i = 1; settle();
    chk("t4_pop_req", mem_req_o, 0);
    chk("t4_pop_rv", core_r_valid_o, 1);
    step(); mem_r_valid_i = 0; settle();
    chk("t4_regnt", core_gnt_o, 1);
    step(); core_req_i = 0; mem_r_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      settle();
      chk($sformatf("t4_drain%0d", i), core_r_valid_o, 1);
    end

    // Test 5: response with empty FIFO -> no routing, sticky error
    step(); settle();
    chk("t5_crv", core_r_valid_o, 0);
    chk("t5_hrv", hwpe_r_valid_o, 0);
    chk("t5_err_pre", err_o, 0);
    step(); mem_r_valid_i = 0; settle();
    chk("t5_err", err_o, 1);
    step(); settle();
    chk("t5_err_sticky", err_o, 1);

    // Test 6: reset with two outstanding and a non-zero stall counter
    step(); core_prio_i = 0; settle();
    step(); core_req_i = 1; hwpe_req_i = 1; mem_gnt_i = 1; settle();
    chk("t6_pre0", hwpe_gnt_o, 1);
    step(); settle();
    chk("t6_pre1", hwpe_gnt_o, 1);
    step(); rst_i = 1; settle();
    chk("t6_rst_req", mem_req_o, 0);
    chk("t6_rst_gnt", hwpe_gnt_o, 0);
    step(); rst_i = 0; mem_gnt_i = 0; mem_r_valid_i = 1; settle();
    chk("t6_req", mem_req_o, 1);
    chk("t6_nogntc", core_gnt_o, 0);
    chk("t6_nognth", hwpe_gnt_o, 0);
    chk("t6_crv", core_r_valid_o, 0);
    chk("t6_hrv", hwpe_r_valid_o, 0);
    chk("t6_err0", err_o, 0);
    for (int i = 0; i < 8; i++) begin
      step(); mem_gnt_i = 1; mem_r_valid_i = (i >= 1); settle();
      if (i == 0) chk("t6_err1", err_o, 1);
      chk($sformatf("t6_cgnt%0d", i), core_gnt_o, (i == 7));
      chk($sformatf("t6_stall%0d", i), stall_core_o, (i == 7));
    end
    step(); core_req_i = 0; hwpe_req_i = 0; mem_r_valid_i = 1; settle();
    chk("t6_last_crv", core_r_valid_o, 1);
    step(); mem_r_valid_i = 0; settle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
